// File: rtl/neuron_seq.sv
// neuron_seq: sequential multiply-accumulate neuron with bias, saturated Q-format sum and sign activation
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start_i           request one evaluation (sampled only while idle)
//   busy_o, done_o    evaluation in progress / one-cycle result-valid pulse
//   x_data_i/x_valid_i/x_ready_o   input sample stream, consumed when valid and ready
//   rom_addr_o, rom_dout_i         registered weight ROM address / data one cycle later
//   sum_o, fire_o     saturated neuron sum and activation (acc >= 0)
module neuron_seq #(
    parameter int N_INPUTS  = 9,
    parameter int BASE_ADDR = 1,
    parameter int FRAC_BITS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    input  logic signed [15:0] x_data_i,
    input  logic               x_valid_i,
    output logic               x_ready_o,
    output logic [15:0]        rom_addr_o,
    input  logic signed [15:0] rom_dout_i,
    output logic signed [15:0] sum_o,
    output logic               fire_o
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, BREQ, BWAIT, FIN} state_t;

    localparam logic [15:0] W_BASE = 16'(BASE_ADDR);
    localparam logic [15:0] B_ADDR = 16'(BASE_ADDR + N_INPUTS);
    localparam logic [15:0] LAST   = 16'(N_INPUTS - 1);

    state_t             state_q;
    logic [15:0]        idx_q;
    logic signed [39:0] acc_q;
    logic signed [31:0] prod;
    logic signed [39:0] mac_d;
    logic signed [39:0] bias_d;
    logic signed [39:0] shifted;
    logic signed [15:0] sum_d;

    assign prod      = rom_dout_i * x_data_i;
    assign mac_d     = acc_q + {{8{prod[31]}}, prod};
    // bias is aligned to the product's fractional point before being added
    assign bias_d    = acc_q + ({{24{rom_dout_i[15]}}, rom_dout_i} <<< FRAC_BITS);
    assign shifted   = acc_q >>> FRAC_BITS;
    assign sum_d     = (shifted > 40'sd32767)  ? 16'sh7FFF :
                       (shifted < -40'sd32768) ? 16'sh8000 : shifted[15:0];
    assign x_ready_o = (state_q == WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            acc_q      <= '0;
            rom_addr_o <= '0;
            sum_o      <= '0;
            fire_o     <= 1'b0;
            done_o     <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_q)
                IDLE: if (start_i) begin
                    state_q    <= REQ;
                    idx_q      <= '0;
                    acc_q      <= '0;
                    rom_addr_o <= W_BASE;
                    busy_o     <= 1'b1;
                end
                REQ: state_q <= WAIT;
                WAIT: if (x_valid_i) begin
                    acc_q <= mac_d;
                    idx_q <= idx_q + 16'd1;
                    state_q    <= (idx_q == LAST) ? BREQ : REQ;
                    rom_addr_o <= (idx_q == LAST) ? B_ADDR : W_BASE + idx_q + 16'd1;
                end
                BREQ: state_q <= BWAIT;
                BWAIT: begin
                    acc_q   <= bias_d;
                    state_q <= FIN;
                end
                FIN: begin
                    sum_o   <= sum_d;
                    fire_o  <= ~acc_q[39];
                    done_o  <= 1'b1;
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_seq.sv
// tb_neuron_seq: directed and randomized checks of neuron_seq against an arithmetic reference model
module tb_neuron_seq;
    logic               clk = 1'b0;
    logic               rst, start, busy, done, x_valid, x_ready, fire;
    logic signed [15:0] x_data, rom_dout, sum;
    logic [15:0]        rom_addr;
    logic signed [15:0] rom [0:31];
    logic signed [15:0] xs  [0:8];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rom_dout <= (rom_addr < 16'd32) ? rom[rom_addr[4:0]] : 16'sd0;

    neuron_seq dut (
        .clk(clk), .rst(rst), .start_i(start), .busy_o(busy), .done_o(done),
        .x_data_i(x_data), .x_valid_i(x_valid), .x_ready_o(x_ready),
        .rom_addr_o(rom_addr), .rom_dout_i(rom_dout), .sum_o(sum), .fire_o(fire)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint model_acc();
        longint a = 0;
        for (int i = 0; i < 9; i++) a += longint'(rom[1+i]) * longint'(xs[i]);
        return a + longint'(rom[10]) * 256;
    endfunction

    function automatic longint model_sum(input longint a);
        longint s = a >>> 8;
        return (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
    endfunction

    task automatic set_std(input int xv);
        for (int i = 0; i < 32; i++) rom[i] = 16'sd0;
        rom[1] = 16'sd1; rom[2] = 16'sd3; rom[3] = 16'sd4; rom[4] = 16'sd5; rom[5] = 16'sd6;
        rom[6] = 16'sd8; rom[7] = 16'sd9; rom[8] = 16'sd10; rom[9] = 16'sd11;
        for (int i = 0; i < 9; i++) xs[i] = 16'(xv);
    endtask

    task automatic run_eval(input string tag, input int stall_idx, input int stall_len, input longint exp_sum, input bit exp_fire);
        int cyc = 0;
        int hs = 0;
        int st = 0;
        bit pend;
        bit got = 0;
        @(negedge clk);
        start = 1'b1; x_valid = 1'b1; x_data = xs[0];
        @(posedge clk);
        #1 start = 1'b0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            x_data  = xs[hs < 9 ? hs : 8];
            x_valid = !(hs == stall_idx && st < stall_len);
            if (x_ready && !x_valid) st++;
            pend = x_ready && x_valid;
            @(posedge clk);
            cyc++;
            if (pend) hs++;
            #1 got = done;
        end
        chk({tag, "_latency"}, cyc, 21 + stall_len);
        chk({tag, "_handshakes"}, hs, 9);
        chk({tag, "_sum"}, sum, exp_sum);
        chk({tag, "_fire"}, fire, exp_fire);
        chk({tag, "_busy_at_done"}, busy, 0);
        @(posedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, done, 0);
        chk({tag, "_sum_hold"}, sum, exp_sum);
    endtask

    initial begin
        longint a;
        int last;
        int n_done;
        rst = 1'b1; start = 1'b0; x_valid = 1'b0; x_data = 16'sd0;
        set_std(256);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_sum", sum, 0);
        chk("reset_fire", fire, 0);
        chk("reset_addr", rom_addr, 0);
        chk("reset_ready", x_ready, 0);
        @(negedge clk) rst = 1'b0;

        set_std(256);
        run_eval("pos", -1, 0, 57, 1'b1);
        set_std(-256);
        run_eval("neg", -1, 0, -57, 1'b0);
        set_std(256);
        run_eval("stall", 3, 3, 57, 1'b1);

        for (int i = 1; i <= 10; i++) rom[i] = 16'sh7FFF;
        for (int i = 0; i < 9; i++) xs[i] = 16'sh7FFF;
        run_eval("sat_hi", -1, 0, 32767, 1'b1);
        for (int i = 1; i <= 9; i++) rom[i] = 16'sd0;
        rom[10] = 16'sh8000;
        run_eval("sat_lo", -1, 0, -32768, 1'b0);

        set_std(256);
        @(negedge clk);
        start = 1'b1; x_valid = 1'b1; x_data = 16'sd256;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_fire", fire, 0);
        chk("midrst_addr", rom_addr, 0);
        chk("midrst_ready", x_ready, 0);
        @(negedge clk) rst = 1'b0;
        run_eval("after_rst", -1, 0, 57, 1'b1);

        for (int k = 0; k < 8; k++) begin
            for (int i = 1; i <= 10; i++) rom[i] = $signed(16'($urandom)) >>> ((k % 2) ? 0 : 6);
            for (int i = 0; i < 9; i++) xs[i] = $signed(16'($urandom)) >>> ((k % 2) ? 0 : 4);
            a = model_acc();
            run_eval($sformatf("rand%0d", k), int'($urandom_range(0, 8)), int'($urandom_range(0, 4)), model_sum(a), a >= 0);
        end

        set_std(256);
        last = 0;
        n_done = 0;
        @(negedge clk);
        start = 1'b1; x_valid = 1'b1; x_data = 16'sd256;
        @(posedge clk);
        for (int c = 1; c <= 70; c++) begin
            @(posedge clk);
            #1;
            chk("b2b_busy", busy, !done);
            if (done) begin
                chk("b2b_gap", c - last, (n_done == 0) ? 21 : 22);
                chk("b2b_sum", sum, 57);
                last = c;
                n_done++;
            end
        end
        chk("b2b_count", n_done, 3);
        @(negedge clk);
        start = 1'b0; rst = 1'b1;
        @(negedge clk) rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/neuron_seq.md
NEURON_SEQ -- requirements
Module: neuron_seq

Interface
REQ-001 Parameter N_INPUTS, default 9: number of weight/input pairs per evaluation.
REQ-002 Parameter BASE_ADDR, default 1: ROM address of weight 0; bias at BASE_ADDR+N_INPUTS.
REQ-003 Parameter FRAC_BITS, default 8: fractional bits of Q-format weights, inputs, bias.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  request one evaluation; sampled only in IDLE.
REQ-007 busy  output  1  evaluation in progress.
REQ-008 done  output  1  one-cycle pulse; sum/fire valid.
REQ-009 x_data  input  16  signed input sample, two's complement.
REQ-010 x_valid  input  1  x_data valid.
REQ-011 x_ready  output  1  sequencer consumes x_data this cycle.
REQ-012 rom_addr  output  16  registered address to weight ROM.
REQ-013 rom_dout  input  16  signed ROM data, valid one cycle after rom_addr is presented.
REQ-014 sum  output  16  signed neuron sum, Q-format, saturated.
REQ-015 fire  output  1  activation: 1 when accumulator >= 0.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, BREQ, BWAIT, FIN.
REQ-017 IDLE: start=1 -> REQ; idx<=0; acc<=0; rom_addr<=BASE_ADDR; busy<=1.
REQ-018 REQ: rom_addr holds BASE_ADDR+idx; unconditional -> WAIT.
REQ-019 WAIT: x_ready = (state==WAIT) combinationally; stays in WAIT while x_valid=0, rom_addr held.
REQ-020 WAIT with x_valid=1: acc <= acc + sext(rom_dout*x_data) (32-bit signed product into 40-bit signed acc); idx++.
REQ-021 WAIT exit: idx==N_INPUTS-1 -> BREQ with rom_addr<=BASE_ADDR+N_INPUTS; else -> REQ with rom_addr<=BASE_ADDR+idx+1.
REQ-022 BREQ -> BWAIT unconditionally; x_ready=0.
REQ-023 BWAIT: acc <= acc + (sext(rom_dout) << FRAC_BITS); -> FIN.
REQ-024 FIN: sum <= sat16(acc >>> FRAC_BITS) (arithmetic shift; clamp to [-32768, 32767]); fire <= ~acc[39]; done<=1; busy<=0; -> IDLE.
REQ-025 done is high exactly one cycle; sum and fire hold until next FIN or reset.
REQ-026 Latency with x_valid held 1: done high 2*N_INPUTS+3 edges after edge sampling start (21 for N=9).
REQ-027 Each x_valid stall cycle adds exactly one cycle of latency; no input consumed outside WAIT.
REQ-028 start while busy ignored; start in done cycle (state IDLE) accepted.
REQ-029 Accumulator never wraps for N_INPUTS <= 256 (40-bit width).
REQ-030 rom_addr changes only on transitions into REQ/BREQ and on reset.

Reset
REQ-031 rst=1 at any edge, including mid-evaluation: state<=IDLE, acc<=0, idx<=0, rom_addr<=0, sum<=0, fire<=0, done<=0, busy<=0; partial result discarded.
REQ-032 rst has priority over start and x_valid on the same edge.

Verification
REQ-033 Bench ROM model: registered, addr 1..9 = 1,3,4,5,6,8,9,10,11; addr 10 = 0.
REQ-034 x_data=256 all nine, x_valid=1, start pulse -> done at edge 21, sum=57, fire=1, 9 x_ready handshakes.
REQ-035 x_data=-256 all nine -> sum=-57, fire=0.
REQ-036 Same as REQ-034 with x_valid low 3 cycles before input 4 -> done at edge 24, sum=57.
REQ-037 ROM model weights all 32767, x_data=32767 -> sum=32767 (saturated), fire=1; bias=-32768 variant with weights 0 -> sum=-32768, fire=0.
REQ-038 rst asserted at edge 10 of an evaluation -> all outputs zero next cycle; new start -> clean result sum=57, no residue.
REQ-039 start held high continuously -> back-to-back evaluations, done every 22 cycles, busy low only in done cycle.
